seg7_scan_decoder: RTL and testbench

//  Parametrised successor to the single-nibble 4-in/7-out segment decode PLA.

---
 rtl/seg7_scan_decoder.sv | 144 ++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Multi-digit hex to 7-segment decoder with a double-buffered load path and a
// prescaled, time-multiplexed scan onto one shared segment bus.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_W      = 16,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NUM_DIGITS-1:0] in_data,
  input  logic [NUM_DIGITS-1:0]   in_dp,
  input  logic [DIV_W-1:0]        scan_div,
  input  logic                    blank_en,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   dig_sel_o,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_POL  = {7{ACTIVE_LOW}};
  localparam logic                  DP_POL   = ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] SEL_POL  = {NUM_DIGITS{ACTIVE_LOW}};

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  logic [IDX_W-1:0]        idx;
  logic [DIV_W-1:0]        cnt;
  logic [4*NUM_DIGITS-1:0] active;
  logic [NUM_DIGITS-1:0]   active_dp;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic                    pending;

  logic                    advance;
  logic                    boundary;
  logic                    accept;
  logic [NUM_DIGITS-1:0]   nz;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [3:0]              cur_nib;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   sel_n;

  // >= rather than == so that lowering scan_div mid-slot advances at once
  assign advance    = (cnt >= scan_div);
  assign boundary   = advance && (idx == LAST_IDX);
  assign accept     = in_valid && !pending;
  assign in_ready   = ~pending;
  assign frame_done = boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      cnt <= '0;
    end else if (advance) begin
      cnt <= '0;
      idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow commits only on a frame boundary; accept cannot coincide with a
  // commit because in_ready is low whenever pending is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= '0;
      active_dp <= '0;
      shadow    <= '0;
      shadow_dp <= '0;
      pending   <= 1'b0;
    end else begin
      if (boundary && pending) begin
        active    <= shadow;
        active_dp <= shadow_dp;
        pending   <= 1'b0;
      end
      if (accept) begin
        shadow    <= in_data;
        shadow_dp <= in_dp;
        pending   <= 1'b1;
      end
    end
  end

  // Digit k>0 is blanked when it and every more significant nibble are zero
  always_comb begin
    nz         = '0;
    blank_mask = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      nz[i] = |active[4*i +: 4];
    end
    for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
      blank_mask[k] = blank_en && ((nz >> k) == '0);
    end
  end

  always_comb begin
    cur_nib    = active[4*idx +: 4];
    seg_n      = blank_mask[idx] ? 7'h00 : hex2seg(cur_nib);
    dp_n       = active_dp[idx];
    sel_n      = '0;
    sel_n[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_o     <= SEG_POL;
      dp_o      <= DP_POL;
      dig_sel_o <= SEL_POL;
    end else begin
      seg_o     <= seg_n ^ SEG_POL;
      dp_o      <= dp_n ^ DP_POL;
      dig_sel_o <= sel_n ^ SEL_POL;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: an active-high and an active-low
// instance share stimulus; a negedge monitor checks displayed frames.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic [3:0]  in_dp;
  logic [15:0] scan_div;
  logic        blank_en;

  logic        in_ready, frame_done, dp_o;
  logic [6:0]  seg_o;
  logic [3:0]  dig_sel_o;
  logic        in_ready_al, frame_done_al, dp_al;
  logic [6:0]  seg_al;
  logic [3:0]  sel_al;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];
  int   ncoll = 0;
  bit   armed = 1'b0;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.NUM_DIGITS(4), .DIV_W(16), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dp(in_dp), .scan_div(scan_div), .blank_en(blank_en),
    .seg_o(seg_o), .dp_o(dp_o), .dig_sel_o(dig_sel_o), .frame_done(frame_done)
  );

  seg7_scan_decoder #(.NUM_DIGITS(4), .DIV_W(16), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_al),
    .in_data(in_data), .in_dp(in_dp), .scan_div(scan_div), .blank_en(blank_en),
    .seg_o(seg_al), .dp_o(dp_al), .dig_sel_o(sel_al), .frame_done(frame_done_al)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_ok(input string name, input bit ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: wait expired before the DUT responded", name);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] sel, input logic [6:0] seg, input logic dp);
    exp_t e;
    e.sel = sel;
    e.seg = seg;
    e.dp  = dp;
    q.push_back(e);
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dps);
    push(4'b0001, s0, dps[0]);
    push(4'b0010, s1, dps[1]);
    push(4'b0100, s2, dps[2]);
    push(4'b1000, s3, dps[3]);
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp, input bit hold);
    bit ok = 1'b0;
    bit rdy;
    in_data  = d;
    in_dp    = dp;
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      rdy = in_ready;
      cyc(1);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!hold) in_valid = 1'b0;
    chk_ok("load accept", ok);
  endtask

  task automatic drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
    chk_ok(name, ok);
    if (!ok) begin
      q.delete();
      ncoll = 0;
      armed = 1'b0;
    end
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
  endtask

  task automatic wait_sel(input logic [3:0] v, input bit eq, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if ((dig_sel_o == v) == eq) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " seg"}, seg_o, 7'h00);
    chk({tag, " dp"}, dp_o, 1'b0);
    chk({tag, " sel"}, dig_sel_o, 4'h0);
    chk({tag, " in_ready"}, in_ready, 1'b1);
    chk({tag, " frame_done"}, frame_done, 1'b0);
    chk({tag, " seg_al"}, seg_al, 7'h7F);
    chk({tag, " dp_al"}, dp_al, 1'b1);
    chk({tag, " sel_al"}, sel_al, 4'hF);
    chk({tag, " in_ready_al"}, in_ready_al, 1'b1);
    chk({tag, " frame_done_al"}, frame_done_al, 1'b0);
  endtask

  // Monitor: a frame starts at the first digit-0 slot after a frame_done that
  // occurred while that frame's expectations were already queued.
  initial begin
    logic [3:0] prev_sel;
    logic [3:0] isel;
    logic [6:0] iseg;
    logic       idp;
    exp_t       e;
    bit         slot;
    prev_sel = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_sel = dig_sel_o;
      end else begin
        slot     = (dig_sel_o != prev_sel);
        prev_sel = dig_sel_o;
        if (slot && q.size() > 0 && (ncoll > 0 || (armed && dig_sel_o == 4'b0001))) begin
          e    = q.pop_front();
          isel = ~e.sel;
          iseg = ~e.seg;
          idp  = ~e.dp;
          chk("frame sel", dig_sel_o, e.sel);
          chk("frame seg", seg_o, e.seg);
          chk("frame dp", dp_o, e.dp);
          chk("frame sel_al", sel_al, isel);
          chk("frame seg_al", seg_al, iseg);
          chk("frame dp_al", dp_al, idp);
          if (ncoll == 0) begin
            ncoll = 3;
            armed = 1'b0;
          end else begin
            ncoll--;
          end
        end
        if (frame_done && q.size() > ncoll) armed = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_dp    = '0;
    scan_div = '0;
    blank_en = 1'b0;
    #1 rst_n = 1'b0;
    #1 chk_reset("por");
    cyc(2);
    rst_n = 1'b1;

    // Basic decode and frame rate with scan_div=0
    load(16'h1234, 4'b0000, 1'b0);
    push_frame(7'h66, 7'h4F, 7'h5B, 7'h06, 4'b0000);
    drain("frame 1234");
    wait_frame(ok);
    chk_ok("frame_done seen", ok);
    cyc(1);
    n = 1;
    while (!frame_done && n < 64) begin
      cyc(1);
      n++;
    end
    chk("frame period div0", n, 4);

    // Leading-zero blanking
    blank_en = 1'b1;
    load(16'h0050, 4'b0000, 1'b0);
    push_frame(7'h3F, 7'h6D, 7'h00, 7'h00, 4'b0000);
    drain("frame 0050 blank");
    blank_en = 1'b0;
    push_frame(7'h3F, 7'h6D, 7'h3F, 7'h3F, 4'b0000);
    drain("frame 0050 noblank");
    blank_en = 1'b1;
    load(16'h0000, 4'b0100, 1'b0);
    push_frame(7'h3F, 7'h00, 7'h00, 7'h00, 4'b0100);
    drain("frame 0000 blank dp");
    load(16'h1000, 4'b0000, 1'b0);
    push_frame(7'h3F, 7'h3F, 7'h3F, 7'h06, 4'b0000);
    drain("frame 1000 blank");
    blank_en = 1'b0;

    // Back-to-back loads: B waits for A to commit
    load(16'hABCD, 4'b0000, 1'b1);
    in_data = 16'h6789;
    in_dp   = 4'b0010;
    push_frame(7'h5E, 7'h39, 7'h7C, 7'h77, 4'b0000);
    ok = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("ready low while pending", in_ready, 1'b0);
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
      cyc(1);
    end
    chk_ok("commit frame_done", ok);
    cyc(1);
    chk("ready after commit", in_ready, 1'b1);
    cyc(1);
    in_valid = 1'b0;
    chk("B held in shadow", in_ready, 1'b0);
    push_frame(7'h6F, 7'h7F, 7'h07, 7'h7D, 4'b0010);
    drain("frames A then B");

    // Polarity: all segments lit, dp only on digit 0
    load(16'h8888, 4'b0001, 1'b0);
    push_frame(7'h7F, 7'h7F, 7'h7F, 7'h7F, 4'b0001);
    drain("frame 8888");

    // Prescaled scan and on-the-fly scan_div change
    scan_div = 16'd3;
    wait_frame(ok);
    chk_ok("div3 frame a", ok);
    cyc(1);
    wait_frame(ok);
    chk_ok("div3 frame b", ok);
    cyc(1);
    n = 1;
    while (!frame_done && n < 64) begin
      cyc(1);
      n++;
    end
    chk("frame period div3", n, 16);
    wait_sel(4'b0010, 1'b0, ok);
    chk_ok("leave dig1", ok);
    wait_sel(4'b0010, 1'b1, ok);
    chk_ok("enter dig1", ok);
    n = 0;
    while (dig_sel_o == 4'b0010 && n < 64) begin
      cyc(1);
      n++;
    end
    chk("dig1 slot length", n, 4);
    wait_sel(4'b0001, 1'b0, ok);
    chk_ok("leave dig0", ok);
    wait_sel(4'b0001, 1'b1, ok);
    chk_ok("enter dig0", ok);
    scan_div = 16'd0;
    cyc(2);
    chk("scan_div lowered mid-slot", dig_sel_o, 4'b0010);

    // Reset during a commit boundary discards the pending value
    load(16'h1111, 4'b0000, 1'b0);
    chk("pending before reset", in_ready, 1'b0);
    wait_frame(ok);
    chk_ok("boundary before reset", ok);
    #2 rst_n = 1'b0;
    #1 chk_reset("mid-scan");
    cyc(2);
    chk_reset("held");
    rst_n = 1'b1;
    push_frame(7'h3F, 7'h3F, 7'h3F, 7'h3F, 4'b0000);
    drain("frame after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
